expr_gen: RTL and testbench

//  Serialises a packed expression descriptor into an ASCII character stream, one char per

---
 rtl/expr_gen.sv | 197 +++++++++++++++++++
 tb/tb_expr_gen.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/expr_gen.sv
// expr_gen: serialises a packed expression descriptor into an ASCII stream.
// Define EXPR_GEN_TERM_EN to append an '=' terminator after the expression.
module expr_gen #(
    parameter int MAX_TERMS = 4
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   start,
    input  logic [3:0]             nterms,
    input  logic [4*MAX_TERMS-1:0] digits,
    input  logic [MAX_TERMS-2:0]   ops,
    input  logic                   paren_en,
    input  logic [2:0]             paren_lo,
    input  logic [2:0]             paren_hi,
    output logic [7:0]             out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   busy,
    output logic                   done,
    output logic                   cfg_err
);

    localparam int KW = $clog2(MAX_TERMS) + 1;
    localparam int IW = KW - 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LPAR, S_DIGIT, S_RPAR, S_OP, S_FIN, S_TERM
    } state_t;

`ifdef EXPR_GEN_TERM_EN
    localparam state_t S_END   = S_TERM;
    localparam logic   EXPR_LAST = 1'b0;
`else
    localparam state_t S_END   = S_FIN;
    localparam logic   EXPR_LAST = 1'b1;
`endif

    state_t                     state_q, state_d;
    logic [KW-1:0]              k_q, k_d;
    logic [3:0]                 n_q, n_d;
    logic [MAX_TERMS-1:0][3:0]  dig_q, dig_d;
    logic [MAX_TERMS-1:0]       ops_q, ops_d;
    logic                       par_q, par_d;
    logic [2:0]                 lo_q, lo_d;
    logic [2:0]                 hi_q, hi_d;
    logic                       err_q, err_d;

    logic [3:0]                 n_s;
    logic                       par_s;
    logic                       err_s;
    logic [MAX_TERMS-1:0][3:0]  dig_s;

    logic [4:0] kx, nx, lx, hx;
    logic [IW-1:0] ki;
    logic more, at_hi, beat;

    // Descriptor clean-up applied at the moment it is latched
    always_comb begin
        n_s   = nterms;
        err_s = 1'b0;
        if (nterms == 4'd0) begin
            n_s   = 4'd1;
            err_s = 1'b1;
        end else if (nterms > 4'(MAX_TERMS)) begin
            n_s   = 4'(MAX_TERMS);
            err_s = 1'b1;
        end
        par_s = paren_en && (paren_lo < paren_hi) && (4'(paren_hi) < n_s);
        if (paren_en && !par_s) err_s = 1'b1;
        for (int i = 0; i < MAX_TERMS; i++) begin
            dig_s[i] = digits[4*i +: 4];
            if (dig_s[i] > 4'd9) begin
                dig_s[i] = 4'd9;
                if (4'(i) < n_s) err_s = 1'b1;
            end
        end
    end

    always_comb begin
        kx    = 5'(k_q);
        nx    = 5'(n_q);
        lx    = 5'(lo_q);
        hx    = 5'(hi_q);
        ki    = k_q[IW-1:0];
        more  = (kx + 5'd1) < nx;
        at_hi = par_q && (kx == hx);

        state_d = state_q;
        k_d     = k_q;
        n_d     = n_q;
        dig_d   = dig_q;
        ops_d   = ops_q;
        par_d   = par_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        err_d   = err_q;

        out       = 8'h00;
        out_valid = 1'b0;
        out_last  = 1'b0;
        beat      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    n_d     = n_s;
                    dig_d   = dig_s;
                    ops_d   = MAX_TERMS'({1'b0, ops});
                    par_d   = par_s;
                    lo_d    = paren_lo;
                    hi_d    = paren_hi;
                    err_d   = err_s;
                    k_d     = '0;
                    state_d = (par_s && paren_lo == 3'd0) ? S_LPAR : S_DIGIT;
                end
            end
            S_LPAR: begin
                out       = 8'h28;
                out_valid = 1'b1;
                beat      = out_ready;
                if (beat) state_d = S_DIGIT;
            end
            S_DIGIT: begin
                out       = 8'h30 + {4'h0, dig_q[ki]};
                out_valid = 1'b1;
                out_last  = !at_hi && !more && EXPR_LAST;
                beat      = out_ready;
                if (beat) begin
                    if (at_hi)     state_d = S_RPAR;
                    else if (more) state_d = S_OP;
                    else           state_d = S_END;
                end
            end
            S_RPAR: begin
                out       = 8'h29;
                out_valid = 1'b1;
                out_last  = !more && EXPR_LAST;
                beat      = out_ready;
                if (beat) state_d = more ? S_OP : S_END;
            end
            S_OP: begin
                out       = ops_q[ki] ? 8'h2A : 8'h2B;
                out_valid = 1'b1;
                beat      = out_ready;
                if (beat) begin
                    k_d     = k_q + KW'(1);
                    state_d = (par_q && (kx + 5'd1) == lx) ? S_LPAR : S_DIGIT;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
`ifdef EXPR_GEN_TERM_EN
            S_TERM: begin
                out       = 8'h3D;
                out_valid = 1'b1;
                out_last  = 1'b1;
                beat      = out_ready;
                if (beat) state_d = S_FIN;
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_FIN);
    assign cfg_err = err_q;

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            n_q     <= 4'd1;
            dig_q   <= '0;
            ops_q   <= '0;
            par_q   <= 1'b0;
            lo_q    <= 3'd0;
            hi_q    <= 3'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            n_q     <= n_d;
            dig_q   <= dig_d;
            ops_q   <= ops_d;
            par_q   <= par_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_expr_gen.sv
// tb_expr_gen: directed vectors for expr_gen, checked against a string-building model.
// Honours EXPR_GEN_TERM_EN to expect the '=' terminator.
module tb_expr_gen;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  nterms = 4'd0;
    logic [15:0] digits = 16'h0;
    logic [2:0]  ops = 3'b0;
    logic        paren_en = 1'b0;
    logic [2:0]  paren_lo = 3'd0;
    logic [2:0]  paren_hi = 3'd0;
    logic [7:0]  out;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_last;
    logic        busy;
    logic        done;
    logic        cfg_err;

    expr_gen #(.MAX_TERMS(4)) dut (
        .clk(clk), .clr(clr), .start(start), .nterms(nterms),
        .digits(digits), .ops(ops), .paren_en(paren_en),
        .paren_lo(paren_lo), .paren_hi(paren_hi), .out(out),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

`ifdef EXPR_GEN_TERM_EN
    string SFX = "=";
`else
    string SFX = "";
`endif

    int         total = 0;
    int         bad = 0;
    logic [7:0] expq[$];
    string      got = "";
    bit         exp_err = 1'b0;
    bit         pend = 1'b0;
    bit         rst_seen = 1'b0;
    logic [7:0] prev_out = 8'h0;
    bit         prev_stall = 1'b0;
    int         pops = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic chk_str(input string name, input string act, input string exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got \"%s\" want \"%s\"", name, act, exp);
        end
    endtask

    // Expected stream built directly from the expression rules
    task automatic model(input int n, input logic [15:0] d, input logic [2:0] o,
                         input bit pe, input int lo, input int hi,
                         output string s, output bit e);
        int nn;
        int v;
        bit par;
        nn = n;
        e  = 1'b0;
        if (nn == 0) begin nn = 1; e = 1'b1; end
        else if (nn > 4) begin nn = 4; e = 1'b1; end
        par = pe && (lo < hi) && (hi < nn);
        if (pe && !par) e = 1'b1;
        s = "";
        for (int k = 0; k < nn; k++) begin
            v = int'(d[4*k +: 4]);
            if (v > 9) begin v = 9; e = 1'b1; end
            if (par && k == lo) s = {s, "("};
            s = {s, $sformatf("%0d", v)};
            if (par && k == hi) s = {s, ")"};
            if (k < nn - 1) s = {s, o[k] ? "*" : "+"};
        end
        s = {s, SFX};
    endtask

    always @(posedge clk) rst_seen <= !clr;

    always @(negedge clk) begin
        if (rst_seen) begin
            chk("rst_valid", {7'b0, out_valid}, 8'h0);
            chk("rst_out", out, 8'h00);
            chk("rst_last", {7'b0, out_last}, 8'h0);
            chk("rst_busy", {7'b0, busy}, 8'h0);
            chk("rst_done", {7'b0, done}, 8'h0);
            chk("rst_err", {7'b0, cfg_err}, 8'h0);
            expq.delete();
            pend = 1'b0;
            prev_stall = 1'b0;
        end else begin
            chk("done", {7'b0, done}, {7'b0, pend});
            pend = 1'b0;
            if (out_valid) begin
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_char: got %0h want none", out);
                end else begin
                    chk("char", out, expq[0]);
                    chk("last", {7'b0, out_last}, {7'b0, expq.size() == 1});
                    chk("cfg_err", {7'b0, cfg_err}, {7'b0, exp_err});
                    chk("busy", {7'b0, busy}, 8'h1);
                    if (prev_stall) chk("stall_hold", out, prev_out);
                    if (out_ready) begin
                        got = {got, $sformatf("%c", out)};
                        void'(expq.pop_front());
                        pops++;
                        if (expq.size() == 0) pend = 1'b1;
                    end
                end
                prev_stall = !out_ready;
                prev_out = out;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    task automatic load(input logic [3:0] n, input logic [15:0] d, input logic [2:0] o,
                        input bit pe, input logic [2:0] lo, input logic [2:0] hi,
                        input string lit, input bit lit_err);
        string s;
        bit e;
        model(int'(n), d, o, pe, int'(lo), int'(hi), s, e);
        chk_str("model_str", s, lit);
        chk("model_err", {7'b0, e}, {7'b0, lit_err});
        nterms = n; digits = d; ops = o;
        paren_en = pe; paren_lo = lo; paren_hi = hi;
        exp_err = e;
        got = "";
        pops = 0;
        for (int i = 0; i < s.len(); i++) expq.push_back(s[i]);
    endtask

    task automatic run(input logic [3:0] n, input logic [15:0] d, input logic [2:0] o,
                       input bit pe, input logic [2:0] lo, input logic [2:0] hi,
                       input logic [3:0] rdy, input bit poke,
                       input string lit, input bit lit_err);
        @(posedge clk);
        #1;
        load(n, d, o, pe, lo, hi, lit, lit_err);
        start = 1'b1;
        out_ready = rdy[0];
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 1; c < 300 && (expq.size() != 0 || pend); c++) begin
            out_ready = rdy[c % 4];
            if (poke && c == 2) begin
                start = 1'b1;
                nterms = 4'd1;
                paren_en = 1'b0;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        if (expq.size() != 0 || pend) begin
            total++;
            bad++;
            $display("FAIL timeout: got %0d chars left want 0", expq.size());
            expq.delete();
            pend = 1'b0;
        end
        chk_str("stream", got, lit);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        clr = 1'b1;

        run(4'd3, 16'h0321, 3'b010, 0, 3'd0, 3'd0, 4'b1111, 0, {"1+2*3", SFX}, 0);
        run(4'd3, 16'h0321, 3'b010, 1, 3'd0, 3'd1, 4'b1111, 0, {"(1+2)*3", SFX}, 0);
        run(4'd3, 16'h0321, 3'b010, 1, 3'd1, 3'd2, 4'b1111, 0, {"1+(2*3)", SFX}, 0);
        run(4'd3, 16'h0321, 3'b010, 1, 3'd0, 3'd1, 4'b1001, 1, {"(1+2)*3", SFX}, 0);
        run(4'd3, 16'h0321, 3'b010, 1, 3'd1, 3'd2, 4'b1001, 0, {"1+(2*3)", SFX}, 0);
        run(4'd1, 16'h0007, 3'b000, 0, 3'd0, 3'd0, 4'b1111, 0, {"7", SFX}, 0);
        run(4'd0, 16'h0007, 3'b000, 0, 3'd0, 3'd0, 4'b1111, 0, {"7", SFX}, 1);
        run(4'd3, 16'h0321, 3'b010, 1, 3'd2, 3'd1, 4'b1111, 0, {"1+2*3", SFX}, 1);
        run(4'd3, 16'h03C1, 3'b010, 0, 3'd0, 3'd0, 4'b1111, 0, {"1+9*3", SFX}, 1);
        run(4'd9, 16'h4321, 3'b101, 0, 3'd0, 3'd0, 4'b1111, 0, {"1*2+3*4", SFX}, 1);
        run(4'd4, 16'h4321, 3'b101, 1, 3'd2, 3'd3, 4'b0110, 0, {"1*2+(3*4)", SFX}, 0);
        run(4'd3, 16'h0321, 3'b010, 1, 3'd1, 3'd3, 4'b1111, 0, {"1+2*3", SFX}, 1);

        @(posedge clk);
        #1;
        load(4'd3, 16'h0321, 3'b010, 0, 3'd0, 3'd0, {"1+2*3", SFX}, 0);
        start = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 0; c < 50 && pops < 2; c++) begin
            @(posedge clk);
            #1;
        end
        chk("abort_pops", 8'(pops), 8'd2);
        clr = 1'b0;
        @(posedge clk);
        #1;
        clr = 1'b1;
        chk_str("abort_stream", got, "1+2");
        repeat (3) @(posedge clk);

        run(4'd3, 16'h0321, 3'b010, 0, 3'd0, 3'd0, 4'b1111, 0, {"1+2*3", SFX}, 0);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
